// File: rtl/cov_acc_pkg.sv
// Shared width helpers and output conversion for the cov_acc covariance estimator.
// COV_ACC_SATURATE_EN selects clamping of out-of-range means instead of MSB wrap.
package cov_acc_pkg;

    // Working width for the saturating compare; covers every legal accumulator width.
    localparam int SAT_W = 64;

    function automatic int prod_width(input int din_w);
        return 2 * din_w;
    endfunction

    function automatic int acc_width(input int din_w, input int len_log2);
        return 2 * din_w + len_log2;
    endfunction

    // Window average plus reduction from 2*DIN_POINT to DOUT_POINT fractional bits.
    function automatic int mean_shift(input int din_point, input int len_log2, input int dout_point);
        return len_log2 + 2 * din_point - dout_point;
    endfunction

`ifdef COV_ACC_SATURATE_EN
    function automatic logic signed [SAT_W-1:0] sat_trunc(
        input  logic signed [SAT_W-1:0] v,
        input  int                      w,
        input  bit                      sgn,
        output logic                    clip
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        if (sgn) begin
            hi = (64'sd1 <<< (w - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (w - 1));
        end else begin
            hi = (64'sd1 <<< w) - 64'sd1;
            lo = '0;
        end
        clip = 1'b0;
        sat_trunc = v;
        if (v > hi) begin
            sat_trunc = hi;
            clip = 1'b1;
        end else if (v < lo) begin
            sat_trunc = lo;
            clip = 1'b1;
        end
    endfunction
`endif

endpackage

// File: rtl/cov_acc_mac.sv
// One multiply-accumulate lane of cov_acc: product, window accumulator, output conversion.
// Honors COV_ACC_SATURATE_EN (clamp and flag) versus plain MSB wrap.
module cov_mac
    import cov_acc_pkg::*;
#(
    parameter int DIN_WIDTH    = 16,
    parameter int DIN_POINT    = 15,
    parameter int ACC_LEN_LOG2 = 10,
    parameter int DOUT_WIDTH   = 16,
    parameter int DOUT_POINT   = 15,
    parameter bit SIGNED_OUT   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIN_WIDTH-1:0]  a,
    input  logic [DIN_WIDTH-1:0]  b,
    input  logic                  vld_p1,
    input  logic                  first_p1,
    input  logic                  dump_p2,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  clip
);
    localparam int PROD_W = prod_width(DIN_WIDTH);
    localparam int ACC_W  = acc_width(DIN_WIDTH, ACC_LEN_LOG2);
    localparam int SHIFT  = mean_shift(DIN_POINT, ACC_LEN_LOG2, DOUT_POINT);

    logic signed [DIN_WIDTH-1:0]  a_s;
    logic signed [DIN_WIDTH-1:0]  b_s;
    logic signed [PROD_W-1:0]     prod_p1;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [ACC_W-1:0]      acc_p2;
    logic signed [ACC_W-1:0]      mean;
    logic [DOUT_WIDTH-1:0]        conv;
    logic                         unused_bits;

    assign a_s = a;
    assign b_s = b;

    // S2: full-precision product
    always_ff @(posedge clk) begin
        prod_p1 <= a_s * b_s;
    end

    assign prod_ext = ACC_W'(prod_p1);

    // S3: a first-tagged product restarts the sum, discarding any stale partial window
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            acc_p2 <= first_p1 ? prod_ext : acc_p2 + prod_ext;
        end
    end

    always_comb begin
        if (SIGNED_OUT) mean = acc_p2 >>> SHIFT;
        else            mean = acc_p2 >> SHIFT;
    end

`ifdef COV_ACC_SATURATE_EN
    logic signed [SAT_W-1:0] clamped;
    always_comb begin
        clip    = 1'b0;
        clamped = sat_trunc(SAT_W'(mean), DOUT_WIDTH, SIGNED_OUT, clip);
        conv    = clamped[DOUT_WIDTH-1:0];
    end
    assign unused_bits = ^clamped[SAT_W-1:DOUT_WIDTH];
`else
    assign conv        = mean[DOUT_WIDTH-1:0];
    assign clip        = 1'b0;
    assign unused_bits = ^mean[ACC_W-1:DOUT_WIDTH];
`endif

    // S4: result register, updated only when a window completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (dump_p2) begin
            dout <= conv;
        end
    end

endmodule

// File: rtl/cov_acc.sv
// Streaming 2x2 covariance estimator: windowed means of x*x, y*y and x*y.
// COV_ACC_SATURATE_EN enables output clamping and the ovf flag.
module cov_acc
    import cov_acc_pkg::*;
#(
    parameter int DIN_WIDTH    = 16,
    parameter int DIN_POINT    = 15,
    parameter int ACC_LEN_LOG2 = 10,
    parameter int DOUT_WIDTH   = 16,
    parameter int DOUT_POINT   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic [DIN_WIDTH-1:0]  din_x,
    input  logic [DIN_WIDTH-1:0]  din_y,
    input  logic                  din_valid,
    input  logic                  sync,
    output logic [DOUT_WIDTH-1:0] r11,
    output logic [DOUT_WIDTH-1:0] r22,
    output logic [DOUT_WIDTH-1:0] r12,
    output logic                  dout_valid,
    output logic                  ovf
);
    logic [ACC_LEN_LOG2-1:0] cnt;
    logic [ACC_LEN_LOG2-1:0] cnt_cur;
    logic                    accept;
    logic                    restart;
    logic                    first;
    logic                    last;

    logic [DIN_WIDTH-1:0]    x_p0;
    logic [DIN_WIDTH-1:0]    y_p0;
    logic                    vld_p0, first_p0, last_p0;
    logic                    vld_p1, first_p1, last_p1;
    logic                    dump_p2;
    logic                    clip11, clip22, clip12;

    always_comb begin
        accept  = din_valid & ce;
        restart = sync & ce;
        cnt_cur = restart ? '0 : cnt;
        first   = (cnt_cur == '0);
        last    = &cnt_cur;
    end

    // The counter width equals log2(N), so the increment wraps N-1 -> 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt_cur + 1'b1;
        end else if (restart) begin
            cnt <= '0;
        end
    end

    // S1: input register
    always_ff @(posedge clk) begin
        x_p0 <= din_x;
        y_p0 <= din_y;
    end

    // S1..S4 control pipeline; in-flight samples of an aborted window are
    // absorbed by the next first-tagged load and never reach a dump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0     <= 1'b0;
            first_p0   <= 1'b0;
            last_p0    <= 1'b0;
            vld_p1     <= 1'b0;
            first_p1   <= 1'b0;
            last_p1    <= 1'b0;
            dump_p2    <= 1'b0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            vld_p0     <= accept;
            first_p0   <= first;
            last_p0    <= last;
            vld_p1     <= vld_p0;
            first_p1   <= first_p0;
            last_p1    <= last_p0;
            dump_p2    <= vld_p1 & last_p1;
            dout_valid <= dump_p2;
            ovf        <= dump_p2 & (clip11 | clip22 | clip12);
        end
    end

    cov_mac #(
        .DIN_WIDTH(DIN_WIDTH), .DIN_POINT(DIN_POINT), .ACC_LEN_LOG2(ACC_LEN_LOG2),
        .DOUT_WIDTH(DOUT_WIDTH), .DOUT_POINT(DOUT_POINT), .SIGNED_OUT(1'b0)
    ) u_r11 (
        .clk(clk), .rst_n(rst_n), .a(x_p0), .b(x_p0), .vld_p1(vld_p1),
        .first_p1(first_p1), .dump_p2(dump_p2), .dout(r11), .clip(clip11)
    );

    cov_mac #(
        .DIN_WIDTH(DIN_WIDTH), .DIN_POINT(DIN_POINT), .ACC_LEN_LOG2(ACC_LEN_LOG2),
        .DOUT_WIDTH(DOUT_WIDTH), .DOUT_POINT(DOUT_POINT), .SIGNED_OUT(1'b0)
    ) u_r22 (
        .clk(clk), .rst_n(rst_n), .a(y_p0), .b(y_p0), .vld_p1(vld_p1),
        .first_p1(first_p1), .dump_p2(dump_p2), .dout(r22), .clip(clip22)
    );

    cov_mac #(
        .DIN_WIDTH(DIN_WIDTH), .DIN_POINT(DIN_POINT), .ACC_LEN_LOG2(ACC_LEN_LOG2),
        .DOUT_WIDTH(DOUT_WIDTH), .DOUT_POINT(DOUT_POINT), .SIGNED_OUT(1'b1)
    ) u_r12 (
        .clk(clk), .rst_n(rst_n), .a(x_p0), .b(y_p0), .vld_p1(vld_p1),
        .first_p1(first_p1), .dump_p2(dump_p2), .dout(r12), .clip(clip12)
    );

endmodule
